// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM state encoding and
// the largest legal BCD digit value.
package bcd_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic digit_bad(input logic [3:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_digit_adder.sv
// Single-digit BCD adder: D = x + y + z with decimal correction, B = decimal carry.
module bcd_digit_adder
    import bcd_serial_adder_ctrl_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       z,
    output logic [3:0] D,
    output logic       B
);

    logic [4:0] s;

    always_comb begin
        s = {1'b0, x} + {1'b0, y} + {4'b0000, z};
        if (s > {1'b0, BCD_MAX}) begin
            // Adding 6 skips the six unused codes; the bit-4 overflow is the carry.
            D = s[3:0] + 4'd6;
            B = 1'b1;
        end else begin
            D = s[3:0];
            B = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit BCD adder: one shared digit adder sequenced LSD first, with a
// start/busy/done handshake; results hold until the next operation completes.
module bcd_serial_adder_ctrl
    import bcd_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              err
);

    localparam int unsigned W  = 4 * NDIG;
    localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    state_t state, state_nxt;

    logic [W-1:0]  a_sh, b_sh, sum_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [3:0]    d_sum;
    logic          d_carry;

    bcd_digit_adder u_digit (
        .x (a_sh[3:0]),
        .y (b_sh[3:0]),
        .z (carry),
        .D (d_sum),
        .B (d_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end
                end
                ADD: begin
                    // Digits enter at the top so the LSD lands at [3:0] after NDIG shifts.
                    sum_sh <= {d_sum, sum_sh[W-1:4]};
                    carry  <= d_carry;
                    a_sh   <= {4'h0, a_sh[W-1:4]};
                    b_sh   <= {4'h0, b_sh[W-1:4]};
                    cnt    <= cnt + CW'(1);
                    if (digit_bad(a_sh[3:0]) || digit_bad(b_sh[3:0]))
                        err <= 1'b1;
                end
                DONE: begin
                    sum  <= sum_sh;
                    cout <= carry;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl (NDIG=4): vector table plus
// handshake corner sequences, results checked through a scoreboard queue.
module tb_bcd_serial_adder_ctrl;

    localparam int unsigned NDIG = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, cout, err;
    logic [15:0] sum;

    bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } vec_t;

    res_t sb_q[$];
    int   nvec = 0;
    int   misc = 0;
    logic [15:0] prev_sum = '0;
    logic        prev_cout = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        res_t e;
        if (rst_n && done === 1'b1) begin
            chk("done_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("err", err, e.err);
            end
        end
    end

    // Called at a falling edge; leaves off at the falling edge where done is seen.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic [15:0] es, input logic ec, input logic ee);
        res_t        r;
        int          n;
        int unsigned c0;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        r.sum = es; r.cout = ec; r.err = ee;
        sb_q.push_back(r);
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        chk("busy_after_start", busy, 1);
        chk("sum_hold", sum, prev_sum);
        chk("cout_hold", cout, prev_cout);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("latency", cyc - c0, NDIG + 1);
        prev_sum = es;
        prev_cout = ec;
    endtask

    vec_t vt[11];

    initial begin : main
        int          nb, n;
        logic [15:0] ra, rb;
        logic        rc;
        int          s;

        vt[0]  = '{16'h0042, 16'h0026, 1'b0, 16'h0068, 1'b0, 1'b0};
        vt[1]  = '{16'h0009, 16'h0007, 1'b1, 16'h0017, 1'b0, 1'b0};
        vt[2]  = '{16'h0055, 16'h0066, 1'b1, 16'h0122, 1'b0, 1'b0};
        vt[3]  = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[4]  = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
        vt[5]  = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vt[6]  = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vt[7]  = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vt[9]  = '{16'hF000, 16'h0000, 1'b0, 16'h5000, 1'b1, 1'b1};
        vt[10] = '{16'h0001, 16'h000B, 1'b0, 16'h0012, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Each op starts on the done cycle of the previous one (back-to-back).
        for (int i = 0; i < 11; i++)
            do_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sum, vt[i].cout, vt[i].err);

        for (int k = 0; k < 8; k++) begin
            ra = '0; rb = '0;
            for (int d = 0; d < 4; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom_range(0, 1));
            s = bcd2int(ra) + bcd2int(rb) + int'(rc);
            do_op(ra, rb, rc, int2bcd(s % 10000), (s >= 10000), 1'b0);
        end

        // start held high while busy must be ignored and busy lasts NDIG+1 cycles
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        sb_q.push_back('{16'h5555, 1'b0, 1'b0});
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; cin = 1'b1;
        nb = 0; n = 0;
        while (busy === 1'b1 && n < 20) begin
            nb++;
            if (nb == 3) start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("busy_cycles", nb, NDIG + 1);
        repeat (8) @(negedge clk);
        chk("ignored_start_busy", busy, 0);
        chk("ignored_start_sum", sum, 16'h5555);
        prev_sum = 16'h5555; prev_cout = 1'b0;

        do_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

        // reset asserted in the second ADD cycle aborts without a done pulse
        @(negedge clk);
        a = 16'h0321; b = 16'h0123; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_idle", busy, 0);
        prev_sum = '0; prev_cout = 1'b0;
        do_op(16'h0321, 16'h0123, 1'b0, 16'h0444, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, misc);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
